// File: rtl/i2c_pkg.sv
// Shared types for the I2C register slave: FSM state encoding, line events
// and the pointer increment helper.
`timescale 1ns/1ps
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WR,
      WR_ACK,
      RD,
      RD_ACK,
      IGNORE
   } state_t;

   // One-clk event strobes produced from the synchronized bus lines.
   typedef struct packed {
      logic start;
      logic stop;
      logic scl_rise;
      logic scl_fall;
   } line_ev_t;

   localparam logic [2:0] SYNC_IDLE = 3'b111;

   function automatic logic [7:0] ptr_inc(input logic [7:0] p, input logic [7:0] last);
      return (p == last) ? 8'd0 : p + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus one history flop each, from which
// SCL edges and START/STOP conditions are decoded.
`timescale 1ns/1ps
module i2c_line_sync
   import i2c_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_scl,
   input  logic     i_sda,
   output logic     o_sda,
   output line_ev_t o_ev
);

   // [1:0] is the synchronizer, [2] the previous synchronized value.
   logic [2:0] r_scl_sh;
   logic [2:0] r_sda_sh;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scl_sh <= SYNC_IDLE;
         r_sda_sh <= SYNC_IDLE;
      end else begin
         r_scl_sh <= {r_scl_sh[1:0], i_scl};
         r_sda_sh <= {r_sda_sh[1:0], i_sda};
      end
   end

   logic w_scl, w_scl_d, w_sda, w_sda_d;
   assign w_scl   = r_scl_sh[1];
   assign w_scl_d = r_scl_sh[2];
   assign w_sda   = r_sda_sh[1];
   assign w_sda_d = r_sda_sh[2];
   assign o_sda   = w_sda;

   always_comb begin
      o_ev.scl_rise = w_scl & ~w_scl_d;
      o_ev.scl_fall = ~w_scl & w_scl_d;
      o_ev.start    = w_scl & w_scl_d & w_sda_d & ~w_sda;
      o_ev.stop     = w_scl & w_scl_d & ~w_sda_d & w_sda;
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C register-file slave (7-bit address, pointer byte then data bytes).
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the pointer after each data byte.
`timescale 1ns/1ps
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h21,
   parameter int         REG_COUNT  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      SCL,
   inout  wire                       SDA,
   output logic [REG_COUNT-1:0][7:0] regs,
   output logic                      wr_stb,
   output logic [7:0]                wr_addr,
   output logic [7:0]                wr_data,
   output logic                      busy,
   output state_t                    o_state
);

   localparam int         LP_IW      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [8:0] LP_REG_CNT = 9'(REG_COUNT);
   localparam logic [7:0] LP_LAST    = 8'(REG_COUNT - 1);

   logic     w_sda;
   line_ev_t w_ev;

   i2c_line_sync u_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_scl   (SCL),
      .i_sda   (SDA),
      .o_sda   (w_sda),
      .o_ev    (w_ev)
   );

   state_t                    r_state, w_nxt_state;
   logic [3:0]                r_bit_cnt, w_nxt_cnt;
   logic [7:0]                r_shift, w_nxt_shift;
   logic [7:0]                r_ptr, w_nxt_ptr;
   logic                      r_sda_oe, w_nxt_oe;
   logic                      r_mack_n, w_nxt_mack_n;
   logic                      r_busy, w_nxt_busy;
   logic                      w_reg_we;
   logic [REG_COUNT-1:0][7:0] r_regs;
   logic                      r_wr_stb;
   logic [7:0]                r_wr_addr, r_wr_data;
   logic [7:0]                w_rd_byte;
   logic [7:0]                w_shift_in;
   logic [7:0]                w_ptr_adv;

   // SDA is only ever pulled low; the async reset clears r_sda_oe at once.
   assign SDA        = r_sda_oe ? 1'b0 : 1'bz;
   assign w_rd_byte  = r_regs[r_ptr[LP_IW-1:0]];
   assign w_shift_in = {r_shift[6:0], w_sda};
`ifdef I2C_SLAVE_AUTOINC_EN
   assign w_ptr_adv  = ptr_inc(r_ptr, LP_LAST);
`else
   assign w_ptr_adv  = r_ptr;
`endif

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cnt    = r_bit_cnt;
      w_nxt_shift  = r_shift;
      w_nxt_ptr    = r_ptr;
      w_nxt_oe     = r_sda_oe;
      w_nxt_mack_n = r_mack_n;
      w_nxt_busy   = r_busy;
      w_reg_we     = 1'b0;
      if (w_ev.stop) begin
         w_nxt_state = IDLE;
         w_nxt_oe    = 1'b0;
         w_nxt_busy  = 1'b0;
      end else if (w_ev.start) begin
         w_nxt_state = ADDR;
         w_nxt_cnt   = 4'd0;
         w_nxt_oe    = 1'b0;
      end else begin
         case (r_state)
            ADDR, PTR, WR: begin
               if (w_ev.scl_rise && r_bit_cnt != 4'd8) begin
                  w_nxt_shift = w_shift_in;
                  w_nxt_cnt   = r_bit_cnt + 4'd1;
               end else if (w_ev.scl_fall && r_bit_cnt == 4'd8) begin
                  if (r_state == ADDR) begin
                     if (r_shift[7:1] == SLAVE_ADDR) begin
                        w_nxt_state = ADDR_ACK;
                        w_nxt_oe    = 1'b1;
                        w_nxt_busy  = 1'b1;
                     end else begin
                        w_nxt_state = IGNORE;
                     end
                  end else if (r_state == PTR) begin
                     if ({1'b0, r_shift} < LP_REG_CNT) begin
                        w_nxt_ptr   = r_shift;
                        w_nxt_state = PTR_ACK;
                        w_nxt_oe    = 1'b1;
                     end else begin
                        w_nxt_state = IGNORE;
                     end
                  end else begin
                     w_reg_we    = 1'b1;
                     w_nxt_ptr   = w_ptr_adv;
                     w_nxt_state = WR_ACK;
                     w_nxt_oe    = 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               if (w_ev.scl_fall) begin
                  w_nxt_cnt = 4'd0;
                  if (r_shift[0]) begin
                     w_nxt_state = RD;
                     w_nxt_shift = w_rd_byte;
                     w_nxt_oe    = ~w_rd_byte[7];
                  end else begin
                     w_nxt_state = PTR;
                     w_nxt_oe    = 1'b0;
                  end
               end
            end
            PTR_ACK, WR_ACK: begin
               if (w_ev.scl_fall) begin
                  w_nxt_state = WR;
                  w_nxt_cnt   = 4'd0;
                  w_nxt_oe    = 1'b0;
               end
            end
            RD: begin
               // Bit 7 is already on the line on entry; each later fall shifts.
               if (w_ev.scl_rise && r_bit_cnt != 4'd8) begin
                  w_nxt_cnt = r_bit_cnt + 4'd1;
               end else if (w_ev.scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     w_nxt_state = RD_ACK;
                     w_nxt_oe    = 1'b0;
                     w_nxt_ptr   = w_ptr_adv;
                  end else begin
                     w_nxt_shift = {r_shift[6:0], 1'b0};
                     w_nxt_oe    = ~r_shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (w_ev.scl_rise) begin
                  w_nxt_mack_n = w_sda;
               end else if (w_ev.scl_fall) begin
                  if (!r_mack_n) begin
                     w_nxt_state = RD;
                     w_nxt_cnt   = 4'd0;
                     w_nxt_shift = w_rd_byte;
                     w_nxt_oe    = ~w_rd_byte[7];
                  end else begin
                     w_nxt_state = IGNORE;
                     w_nxt_oe    = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'd0;
         r_ptr     <= 8'd0;
         r_sda_oe  <= 1'b0;
         r_mack_n  <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_bit_cnt <= w_nxt_cnt;
         r_shift   <= w_nxt_shift;
         r_ptr     <= w_nxt_ptr;
         r_sda_oe  <= w_nxt_oe;
         r_mack_n  <= w_nxt_mack_n;
         r_busy    <= w_nxt_busy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs    <= '0;
         r_wr_stb  <= 1'b0;
         r_wr_addr <= 8'd0;
         r_wr_data <= 8'd0;
      end else begin
         r_wr_stb <= w_reg_we;
         if (w_reg_we) begin
            r_regs[r_ptr[LP_IW-1:0]] <= r_shift;
            r_wr_addr                <= r_ptr;
            r_wr_data                <= r_shift;
         end
      end
   end

   assign regs    = r_regs;
   assign wr_stb  = r_wr_stb;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign busy    = r_busy;
   assign o_state = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: write, read with repeated START, address
// mismatch, pointer out of range, pointer wrap and reset abort.
`timescale 1ns/1ps
module tb_i2c_slave;
   import i2c_pkg::*;

`ifdef I2C_SLAVE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif
   localparam int Q = 50;

   logic          clk;
   logic          rst_n;
   logic          scl;
   logic          m_oe;
   wire           sda;
   logic [15:0][7:0] regs;
   logic          wr_stb;
   logic [7:0]    wr_addr, wr_data;
   logic          busy;
   state_t        o_state;

   pullup (sda);
   assign sda = m_oe ? 1'b0 : 1'bz;

   i2c_slave #(.SLAVE_ADDR(7'h21), .REG_COUNT(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SCL     (scl),
      .SDA     (sda),
      .regs    (regs),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .o_state (o_state)
   );

   // Clock edges sit at 7+10k / 12+10k so bus activity at multiples of 50 avoids them.
   initial begin
      clk = 1'b0;
      #2;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int stb_cnt  = 0;
   logic mon_en = 1'b0;
   logic drv_seen = 1'b0;
   logic busy_seen = 1'b0;

   always @(negedge clk) begin
      if (wr_stb) stb_cnt++;
      if (mon_en) begin
         if (sda === 1'b0 && !m_oe) drv_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic i2c_start();
      m_oe = 1'b0; scl = 1'b1; #Q;
      m_oe = 1'b1; #Q;
      scl = 1'b0; #Q;
   endtask

   task automatic i2c_rstart();
      m_oe = 1'b0; #Q;
      scl = 1'b1; #Q;
      m_oe = 1'b1; #Q;
      scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_oe = 1'b1; #Q;
      scl = 1'b1; #Q;
      m_oe = 1'b0; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         m_oe = ~b[i]; #Q;
         scl = 1'b1; #Q;
         scl = 1'b0; #Q;
      end
      m_oe = 1'b0; #Q;
      scl = 1'b1; #(Q/2);
      ack = sda; #(Q/2);
      scl = 1'b0; #Q;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b);
      m_oe = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl = 1'b1; #(Q/2);
         b[i] = sda; #(Q/2);
         scl = 1'b0;
      end
      m_oe = mack; #Q;
      scl = 1'b1; #Q;
      scl = 1'b0; m_oe = 1'b0; #Q;
   endtask

   logic          a0, a1, a2, a3;
   logic [7:0]    d0, d1;
   logic [15:0][7:0] snap;
   int            stb0;

   initial begin
      rst_n = 1'b0; scl = 1'b1; m_oe = 1'b0;
      #40;
      check("rst_regs", 32'(|regs), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stb", 32'(wr_stb), 32'd0);
      check("rst_waddr", 32'(wr_addr), 32'd0);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_state", 32'(o_state), 32'(IDLE));
      #60; rst_n = 1'b1; #100;

      // Write 0xA5 to register 5
      i2c_start();
      wr_byte(8'h42, a0);
      check("wr_busy", 32'(busy), 32'd1);
      wr_byte(8'h05, a1);
      wr_byte(8'hA5, a2);
      i2c_stop();
      check("wr_ack_addr", 32'(a0), 32'd0);
      check("wr_ack_ptr", 32'(a1), 32'd0);
      check("wr_ack_data", 32'(a2), 32'd0);
      check("wr_reg5", 32'(regs[5]), 32'hA5);
      check("wr_stb_cnt", 32'(stb_cnt), 32'd1);
      check("wr_addr", 32'(wr_addr), 32'd5);
      check("wr_data", 32'(wr_data), 32'hA5);
      check("wr_busy_end", 32'(busy), 32'd0);

      // Preload register 6 so an incrementing read is distinguishable
      i2c_start(); wr_byte(8'h42, a0); wr_byte(8'h06, a1); wr_byte(8'h3C, a2); i2c_stop();
      check("pre_reg6", 32'(regs[6]), 32'h3C);

      // Read two bytes from register 5 via repeated START
      i2c_start();
      wr_byte(8'h42, a0);
      wr_byte(8'h05, a1);
      i2c_rstart();
      wr_byte(8'h43, a2);
      rd_byte(1'b1, d0);
      rd_byte(1'b0, d1);
      i2c_stop();
      check("rd_ack_addr", 32'(a0), 32'd0);
      check("rd_ack_ptr", 32'(a1), 32'd0);
      check("rd_ack_raddr", 32'(a2), 32'd0);
      check("rd_byte0", 32'(d0), 32'hA5);
      check("rd_byte1", 32'(d1), AUTOINC ? 32'h3C : 32'hA5);
      check("rd_state_end", 32'(o_state), 32'(IDLE));

      // Address mismatch: the slave must stay off the bus
      snap = regs; stb0 = stb_cnt;
      drv_seen = 1'b0; busy_seen = 1'b0; mon_en = 1'b1;
      i2c_start();
      wr_byte(8'h44, a0);
      wr_byte(8'h00, a1);
      i2c_stop();
      mon_en = 1'b0;
      check("mis_ack_addr", 32'(a0), 32'd1);
      check("mis_ack_data", 32'(a1), 32'd1);
      check("mis_sda_drv", 32'(drv_seen), 32'd0);
      check("mis_busy", 32'(busy_seen), 32'd0);
      check("mis_regs", 32'(regs == snap), 32'd1);
      check("mis_stb", 32'(stb_cnt - stb0), 32'd0);

      // Pointer out of range
      snap = regs; stb0 = stb_cnt;
      i2c_start();
      wr_byte(8'h42, a0);
      wr_byte(8'h10, a1);
      wr_byte(8'h77, a2);
      i2c_stop();
      check("oor_ack_addr", 32'(a0), 32'd0);
      check("oor_nack_ptr", 32'(a1), 32'd1);
      check("oor_nack_data", 32'(a2), 32'd1);
      check("oor_regs", 32'(regs == snap), 32'd1);
      check("oor_stb", 32'(stb_cnt - stb0), 32'd0);

      // Two writes starting at the last register
      stb0 = stb_cnt;
      i2c_start();
      wr_byte(8'h42, a0);
      wr_byte(8'h0F, a1);
      wr_byte(8'h11, a2);
      wr_byte(8'h22, a3);
      i2c_stop();
      check("wrap_ack", 32'({a0, a1, a2, a3}), 32'd0);
      check("wrap_reg15", 32'(regs[15]), AUTOINC ? 32'h11 : 32'h22);
      check("wrap_reg0", 32'(regs[0]), AUTOINC ? 32'h22 : 32'h00);
      check("wrap_stb", 32'(stb_cnt - stb0), 32'd2);
      check("wrap_waddr", 32'(wr_addr), AUTOINC ? 32'd0 : 32'd15);

      // Reset while the slave is driving a 0 data bit (reg 15 bit 7 is 0)
      i2c_start();
      wr_byte(8'h42, a0);
      wr_byte(8'h0F, a1);
      i2c_rstart();
      wr_byte(8'h43, a2);
      check("abt_state", 32'(o_state), 32'(RD));
      check("abt_sda_low", 32'(sda), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abt_sda_rel", 32'(sda), 32'd1);
      check("abt_regs", 32'(|regs), 32'd0);
      check("abt_busy", 32'(busy), 32'd0);
      #49;
      rst_n = 1'b1; #Q;
      i2c_stop();
      check("abt_idle", 32'(o_state), 32'(IDLE));

      // Bus works normally after the abort
      i2c_start(); wr_byte(8'h42, a0); wr_byte(8'h02, a1); wr_byte(8'h5A, a2); i2c_stop();
      check("post_wr_ack", 32'({a0, a1, a2}), 32'd0);
      check("post_reg2", 32'(regs[2]), 32'h5A);
      i2c_start(); wr_byte(8'h42, a0); wr_byte(8'h02, a1);
      i2c_rstart(); wr_byte(8'h43, a2); rd_byte(1'b0, d0); i2c_stop();
      check("post_rd", 32'(d0), 32'h5A);

      // Read with no pointer byte uses the retained pointer
      i2c_start(); wr_byte(8'h43, a0); rd_byte(1'b0, d1); i2c_stop();
      check("ret_ack", 32'(a0), 32'd0);
      check("ret_rd", 32'(d1), AUTOINC ? 32'h00 : 32'h5A);

      #200;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
